// File: rtl/cic3_row_readout.sv
// Snapshots a CIC3 filter row output bus on sample_stb and streams the captured
// words one filter at a time over valid/ready, flagging strobes that arrive too early.
module cic3_row_readout #(
  parameter int NUM_FILTERS_SUBSECTION = 12,
  parameter int NUM_SUBSECTIONS        = 2,
  parameter int WORD_W                 = 25,
  parameter int OVR_CNT_W              = 8,
  localparam int NUM_WORDS             = NUM_FILTERS_SUBSECTION * NUM_SUBSECTIONS,
  localparam int IDX_W                 = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_WORDS*WORD_W-1:0] filt_in,
  input  logic                        sample_stb,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [WORD_W-1:0]           rd_data,
  output logic [IDX_W-1:0]            rd_index,
  output logic                        rd_sof,
  output logic                        rd_eof,
  output logic                        busy,
  output logic                        overrun,
  output logic [OVR_CNT_W-1:0]        overrun_cnt,
  input  logic                        overrun_clr,
  output logic                        state_dbg
);

  // Handshake: a word moves on rd_valid & rd_ready; while rd_valid is high and
  // rd_ready low every rd_* output holds. rd_valid is a pure function of state,
  // so rd_ready never reaches it combinationally.

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state;
  logic [IDX_W-1:0]  index;
  logic [WORD_W-1:0] shadow [NUM_WORDS];

  logic xfer;
  logic eof_xfer;
  logic load;
  logic ovr_evt;

  assign xfer     = (state == STREAM) && rd_ready;
  assign eof_xfer = xfer && (index == LAST_IDX);
  // A strobe is welcome in IDLE or exactly on the eof transfer; anywhere else it is dropped.
  assign load     = sample_stb && ((state == IDLE) || eof_xfer);
  assign ovr_evt  = sample_stb && (state == STREAM) && !eof_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      index       <= '0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_stb) begin
            state <= STREAM;
            index <= '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (index == LAST_IDX) begin
              index <= '0;
              if (!sample_stb) state <= IDLE;
            end else begin
              index <= index + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase

      if (load) begin
        for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= filt_in[k*WORD_W +: WORD_W];
      end

      // Clear has priority; an overrun landing in the same cycle is lost.
      if (overrun_clr) begin
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end else if (ovr_evt) begin
        overrun <= 1'b1;
        if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_CNT_W'(1);
      end
    end
  end

  assign rd_valid  = (state == STREAM);
  assign busy      = (state == STREAM);
  assign rd_data   = shadow[index];
  assign rd_index  = index;
  assign rd_sof    = rd_valid && (index == '0);
  assign rd_eof    = rd_valid && (index == LAST_IDX);
  assign state_dbg = state;

endmodule

// File: tb/tb_cic3_row_readout.sv
// Bench for cic3_row_readout: each captured frame becomes 24 expected {index,data}
// entries in exp_q, popped as transfers are observed on the falling edge.
module tb_cic3_row_readout;

  localparam int W  = 25;
  localparam int NW = 24;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NW*W-1:0]   filt_in;
  logic              sample_stb;
  logic              rd_valid;
  logic              rd_ready;
  logic [W-1:0]      rd_data;
  logic [4:0]        rd_index;
  logic              rd_sof;
  logic              rd_eof;
  logic              busy;
  logic              overrun;
  logic [7:0]        overrun_cnt;
  logic              overrun_clr;
  logic              state_dbg;

  int tests = 0;
  int fails = 0;

  logic [29:0] exp_q[$];
  logic [W-1:0] words [NW];

  cic3_row_readout dut (
    .clk(clk), .reset_n(reset_n), .filt_in(filt_in), .sample_stb(sample_stb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_index(rd_index),
    .rd_sof(rd_sof), .rd_eof(rd_eof), .busy(busy), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .overrun_clr(overrun_clr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NW*W-1:0] pack_words();
    logic [NW*W-1:0] v;
    for (int k = 0; k < NW; k++) v[k*W +: W] = words[k];
    return v;
  endfunction

  function automatic void rand_words();
    for (int k = 0; k < NW; k++) words[k] = W'($urandom);
  endfunction

  function automatic void push_frame();
    for (int k = 0; k < NW; k++) exp_q.push_back({5'(k), words[k]});
  endfunction

  function automatic logic [33:0] want_of(input logic [29:0] e);
    return {1'b1, 1'b1, e[29:25] == 5'd0, e[29:25] == 5'd23, e};
  endfunction

  task automatic start_frame();
    @(negedge clk);
    filt_in    = pack_words();
    sample_stb = 1'b1;
    push_frame();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample_stb = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    filt_in = '1;
    repeat (3) @(negedge clk);
    tests++;
    if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data, overrun, overrun_cnt, state_dbg} !== '0)
      begin fails++; $display("FAIL reset_outputs: got %h want 0",
        {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data, overrun, overrun_cnt, state_dbg}); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({rd_valid, busy} !== 2'b00)
      begin fails++; $display("FAIL idle_after_reset: got %b want 00", {rd_valid, busy}); end
  endtask

  task automatic test_basic();
    logic [29:0] e;
    for (int k = 0; k < NW; k++) words[k] = W'(k + 1);
    rd_ready = 1'b1;
    start_frame();
    for (int c = 0; c < NW; c++) begin
      @(negedge clk);
      sample_stb = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(e))
        begin fails++; $display("FAIL basic_word%0d: got %h want %h", c,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(e)); end
    end
    @(negedge clk);
    rd_ready = 1'b0;
    tests++;
    if ({rd_valid, busy, rd_sof, rd_eof} !== 4'b0000)
      begin fails++; $display("FAIL basic_end: got %b want 0000", {rd_valid, busy, rd_sof, rd_eof}); end
  endtask

  task automatic test_stall();
    int xfers = 0;
    int cyc = 0;
    logic rdy;
    rand_words();
    start_frame();
    while (xfers < NW && cyc < 200) begin
      @(negedge clk);
      sample_stb = 1'b0;
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      rd_ready = rdy;
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(exp_q[0]))
        begin fails++; $display("FAIL stall_cyc%0d: got %h want %h", cyc,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(exp_q[0])); end
      if (rdy) begin void'(exp_q.pop_front()); xfers++; end
      cyc++;
    end
    tests++;
    if (xfers != NW) begin fails++; $display("FAIL stall_timeout: got %0d transfers want %0d", xfers, NW); end
    @(negedge clk);
    rd_ready = 1'b0;
    tests++;
    if ({rd_valid, busy} !== 2'b00)
      begin fails++; $display("FAIL stall_end: got %b want 00", {rd_valid, busy}); end
    exp_q.delete();
  endtask

  task automatic test_overrun();
    int xfers = 0;
    int cyc = 0;
    logic rdy;
    logic injected = 1'b0;
    rand_words();
    start_frame();
    while (xfers < NW && cyc < 300) begin
      @(negedge clk);
      sample_stb = 1'b0;
      rdy = 1'($urandom_range(0, 1));
      rd_ready = rdy;
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(exp_q[0]))
        begin fails++; $display("FAIL ovr_cyc%0d: got %h want %h", cyc,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(exp_q[0])); end
      if (!injected && exp_q[0][29:25] == 5'd5) begin
        sample_stb = 1'b1;
        filt_in    = ~filt_in;
        injected   = 1'b1;
      end
      if (rdy) begin void'(exp_q.pop_front()); xfers++; end
      cyc++;
    end
    @(negedge clk);
    sample_stb = 1'b0; rd_ready = 1'b0;
    tests++;
    if ({rd_valid, overrun, overrun_cnt} !== {1'b0, 1'b1, 8'd1})
      begin fails++; $display("FAIL ovr_flag: got %h want %h", {rd_valid, overrun, overrun_cnt}, {1'b0, 1'b1, 8'd1}); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    tests++;
    if ({overrun, overrun_cnt} !== 9'd0)
      begin fails++; $display("FAIL ovr_clear: got %h want 0", {overrun, overrun_cnt}); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int xfers = 0;
    logic b2b = 1'b0;
    rand_words();
    rd_ready = 1'b1;
    start_frame();
    while (xfers < 2*NW) begin
      @(negedge clk);
      sample_stb = 1'b0;
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(exp_q[0]))
        begin fails++; $display("FAIL b2b_xfer%0d: got %h want %h", xfers,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(exp_q[0])); end
      if (!b2b && exp_q[0][29:25] == 5'd23) begin
        for (int k = 0; k < NW; k++) words[k] = 25'h1FFFFFF;
        filt_in    = pack_words();
        sample_stb = 1'b1;
        b2b        = 1'b1;
        void'(exp_q.pop_front());
        push_frame();
      end else begin
        void'(exp_q.pop_front());
      end
      xfers++;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    tests++;
    if ({rd_valid, overrun, overrun_cnt} !== 10'd0)
      begin fails++; $display("FAIL b2b_end: got %h want 0", {rd_valid, overrun, overrun_cnt}); end
  endtask

  task automatic test_saturation();
    int model_cnt = 0;
    logic [29:0] e;
    rand_words();
    rd_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 305; i++) begin
      @(negedge clk);
      if (i == 128 || i == 300) begin
        tests++;
        if (overrun_cnt !== 8'(model_cnt))
          begin fails++; $display("FAIL sat_cnt_at%0d: got %0d want %0d", i, overrun_cnt, model_cnt); end
      end
      sample_stb = 1'b1;
      filt_in    = {NW*W/32+1{$urandom}};
      if (model_cnt < 255) model_cnt++;
    end
    @(negedge clk);
    sample_stb = 1'b0;
    tests++;
    if ({overrun, overrun_cnt} !== {1'b1, 8'd255})
      begin fails++; $display("FAIL sat_hold: got %h want %h", {overrun, overrun_cnt}, {1'b1, 8'd255}); end
    sample_stb = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0; overrun_clr = 1'b0;
    tests++;
    if ({overrun, overrun_cnt} !== 9'd0)
      begin fails++; $display("FAIL clr_wins: got %h want 0", {overrun, overrun_cnt}); end
    rd_ready = 1'b1;
    for (int c = 0; c < NW; c++) begin
      e = exp_q.pop_front();
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(e))
        begin fails++; $display("FAIL sat_drain%0d: got %h want %h", c,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(e)); end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    tests++;
    if (rd_valid !== 1'b0) begin fails++; $display("FAIL sat_end: got %b want 0", rd_valid); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] e;
    rand_words();
    rd_ready = 1'b1;
    start_frame();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sample_stb = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(e))
        begin fails++; $display("FAIL rmid_word%0d: got %h want %h", c,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(e)); end
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data, overrun, overrun_cnt, state_dbg} !== '0)
      begin fails++; $display("FAIL rmid_async: got %h want 0",
        {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data, overrun, overrun_cnt, state_dbg}); end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    rand_words();
    start_frame();
    for (int c = 0; c < NW; c++) begin
      @(negedge clk);
      sample_stb = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if ({rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data} !== want_of(e))
        begin fails++; $display("FAIL rmid_new%0d: got %h want %h", c,
          {rd_valid, busy, rd_sof, rd_eof, rd_index, rd_data}, want_of(e)); end
    end
    @(negedge clk);
    rd_ready = 1'b0;
    tests++;
    if ({rd_valid, busy} !== 2'b00) begin fails++; $display("FAIL rmid_end: got %b want 00", {rd_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
